hilo_muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer that produces the 64-bit value loaded into the HI/LO register pair.
- Accepts one operation via a start/busy/done handshake and runs a radix-2 shift-add multiply or a restoring divide over DATA_WIDTH cycles.
- Drives the 64-bit HI/LO data input and a one-cycle load enable; HI is the upper half, LO the lower half.

---
 rtl/hilo_pkg.sv | 27 ++
 rtl/hilo_muldiv_ctrl_addsub.sv | 22 ++
 rtl/hilo_muldiv_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_DIV  = 2'b01,
      OP_MULU = 2'b10,
      OP_DIVU = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      RUN   = 3'd2,
      FIXUP = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Widest operand the divide-by-zero constant can cover.
   localparam int unsigned MAX_DATA_WIDTH = 64;
   localparam logic [MAX_DATA_WIDTH-1:0] DIV0_LO = '1;

   function automatic logic is_div_op(input op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_addsub.sv
// W+1-bit adder/subtractor with carry-out, shared by the multiply
// accumulate step and the restoring-divide trial subtract.
module muldiv_addsub #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH:0] i_a,
   input  logic [DATA_WIDTH:0] i_b,
   input  logic                i_sub,
   output logic [DATA_WIDTH:0] o_sum,
   output logic                o_cout
);

   logic [DATA_WIDTH:0]   w_b_eff;
   logic [DATA_WIDTH+1:0] w_full;

   // Subtract as a + ~b + 1; carry-out high means a >= b.
   assign w_b_eff = i_sub ? ~i_b : i_b;
   assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{(DATA_WIDTH+1){1'b0}}, i_sub};
   assign o_sum   = w_full[DATA_WIDTH:0];
   assign o_cout  = w_full[DATA_WIDTH+1];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative radix-2 multiply / restoring divide feeding the HI/LO pair.
// HILO_MULDIV_UNSIGNED_EN enables MULU/DIVU; otherwise every op is signed.
//
// state | meaning
// IDLE  | waiting for start; latches op, a, b
// PREP  | forms magnitudes and result signs; catches divide by zero
// RUN   | one shift-add / trial-subtract iteration per cycle
// FIXUP | negates product, quotient or remainder as required
// DONE  | done / hilo_en pulse with hilo_d valid
module hilo_muldiv_ctrl
   import hilo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    i_clock,
   input  logic                    i_clear,
   input  logic                    i_start,
   input  logic [1:0]              i_op,
   input  logic [DATA_WIDTH-1:0]   i_a,
   input  logic [DATA_WIDTH-1:0]   i_b,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [2*DATA_WIDTH-1:0] o_hilo_d,
   output logic                    o_hilo_en
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

   state_e          r_state;
   state_e          w_state_nxt;
   op_e             r_op;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_hi;
   logic [W-1:0]    r_lo;
   logic [W-1:0]    r_dsr;
   logic [CW-1:0]   r_cnt;
   logic            r_neg_q;
   logic            r_neg_r;
   logic [2*W-1:0]  r_hilo;

   logic            w_is_div;
   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [W-1:0]    w_a_mag;
   logic [W-1:0]    w_b_mag;
   logic            w_b_zero;
   logic            w_div0;
   logic [W:0]      w_as_a;
   logic [W:0]      w_as_b;
   logic [W:0]      w_as_sum;
   logic            w_as_cout;
   logic [W:0]      w_div_shift;
   logic [2*W-1:0]  w_prod;
   logic [2*W-1:0]  w_prod_fix;
   logic [W-1:0]    w_quo_fix;
   logic [W-1:0]    w_rem_fix;
   logic [2*W-1:0]  w_result;

   assign w_is_div = is_div_op(r_op);

`ifdef HILO_MULDIV_UNSIGNED_EN
   assign w_signed = (r_op == OP_MUL) || (r_op == OP_DIV);
`else
   assign w_signed = 1'b1;
`endif

   assign w_a_neg  = w_signed & r_a[W-1];
   assign w_b_neg  = w_signed & r_b[W-1];
   // Magnitude of the most-negative value still fits as an unsigned W-bit number.
   assign w_a_mag  = w_a_neg ? -r_a : r_a;
   assign w_b_mag  = w_b_neg ? -r_b : r_b;
   assign w_b_zero = (r_b == '0);
   assign w_div0   = w_is_div & w_b_zero;

   assign w_div_shift = {r_hi, r_lo[W-1]};
   assign w_as_a      = w_is_div ? w_div_shift : {1'b0, r_hi};
   assign w_as_b      = {1'b0, r_dsr};

   muldiv_addsub #(
      .DATA_WIDTH (W)
   ) u_addsub (
      .i_a    (w_as_a),
      .i_b    (w_as_b),
      .i_sub  (w_is_div),
      .o_sum  (w_as_sum),
      .o_cout (w_as_cout)
   );

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_quo_fix  = r_neg_q ? -r_lo : r_lo;
   assign w_rem_fix  = r_neg_r ? -r_hi : r_hi;
   assign w_result   = w_is_div ? {w_rem_fix, w_quo_fix} : w_prod_fix;

   always_ff @(posedge i_clock) begin
      if (!i_clear) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_hilo_en   = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = PREP;
            end
         end
         PREP: begin
            o_busy      = 1'b1;
            w_state_nxt = w_div0 ? DONE : RUN;
         end
         RUN: begin
            o_busy = 1'b1;
            if (r_cnt == CW'(1)) begin
               w_state_nxt = FIXUP;
            end
         end
         FIXUP: begin
            o_busy      = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            o_done      = 1'b1;
            o_hilo_en   = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_clear) begin
         r_op    <= OP_MUL;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_dsr   <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_hilo  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_op <= op_e'(i_op);
                  r_a  <= i_a;
                  r_b  <= i_b;
               end
            end
            PREP: begin
               r_neg_q <= w_a_neg ^ w_b_neg;
               r_neg_r <= w_a_neg;
               r_hi    <= '0;
               r_cnt   <= CW'(W);
               if (w_is_div) begin
                  r_lo  <= w_a_mag;
                  r_dsr <= w_b_mag;
               end else begin
                  r_lo  <= w_b_mag;
                  r_dsr <= w_a_mag;
               end
               if (w_div0) begin
                  r_hilo <= {r_a, DIV0_LO[W-1:0]};
               end
            end
            RUN: begin
               r_cnt <= r_cnt - CW'(1);
               if (w_is_div) begin
                  // Dividend bits leave the top of LO as quotient bits enter the bottom.
                  r_hi <= w_as_cout ? w_as_sum[W-1:0] : w_div_shift[W-1:0];
                  r_lo <= {r_lo[W-2:0], w_as_cout};
               end else if (r_lo[0]) begin
                  r_hi <= w_as_sum[W:1];
                  r_lo <= {w_as_sum[0], r_lo[W-1:1]};
               end else begin
                  r_hi <= {1'b0, r_hi[W-1:1]};
                  r_lo <= {r_hi[0], r_lo[W-1:1]};
               end
            end
            FIXUP: begin
               r_hilo <= w_result;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_hilo_d = r_hilo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl (DATA_WIDTH=32).
module tb_hilo_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        clear;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [63:0] hilo_d;
   logic        hilo_en;

   int n_cmp  = 0;
   int n_fail = 0;

   hilo_muldiv_ctrl #(
      .DATA_WIDTH (32)
   ) dut (
      .i_clock   (clk),
      .i_clear   (clear),
      .i_start   (start),
      .i_op      (op),
      .i_a       (a),
      .i_b       (b),
      .o_busy    (busy),
      .o_done    (done),
      .o_hilo_d  (hilo_d),
      .o_hilo_en (hilo_en)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle, which becomes cycle 0; returns in cycle lat+1.
   task automatic run_op(input string tag, input logic [1:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, input int lat, input logic [63:0] exp,
                         input bit hold, input bit pulse10);
      start = 1'b1;
      op    = t_op;
      a     = t_a;
      b     = t_b;
      chk({tag, "/c0_ctl"}, {61'd0, busy, done, hilo_en}, 64'b000);
      for (int c = 1; c <= lat + 1; c++) begin
         step();
         if (!hold) begin
            if (pulse10 && c == 10) begin
               start = 1'b1;
               a     = 32'd1;
               b     = 32'd1;
            end else begin
               start = 1'b0;
            end
         end
         if (c < lat) begin
            chk({tag, "/run_ctl"}, {61'd0, busy, done, hilo_en}, 64'b100);
         end else if (c == lat) begin
            chk({tag, "/done_ctl"}, {61'd0, busy, done, hilo_en}, 64'b011);
            chk({tag, "/hilo_d"}, hilo_d, exp);
         end else begin
            chk({tag, "/after_ctl"}, {61'd0, busy, done, hilo_en}, 64'b000);
            chk({tag, "/hilo_hold"}, hilo_d, exp);
         end
      end
   endtask

   initial begin
      clear = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      a     = 32'd0;
      b     = 32'd0;
      step();
      step();
      chk("reset_ctl", {61'd0, busy, done, hilo_en}, 64'b000);
      chk("reset_hilo", hilo_d, 64'd0);
      clear = 1'b1;
      step();

      run_op("mul_7_m3",   2'b00, 32'd7,        32'hFFFFFFFD, 35, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b0);
      run_op("div_m7_2",   2'b01, 32'hFFFFFFF9, 32'd2,        35, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0);
      run_op("div_7_m2",   2'b01, 32'd7,        32'hFFFFFFFE, 35, 64'h00000001_FFFFFFFD, 1'b0, 1'b0);
      run_op("div_ovf",    2'b01, 32'h80000000, 32'hFFFFFFFF, 35, 64'h00000000_80000000, 1'b0, 1'b0);
      run_op("div_5_0",    2'b01, 32'd5,        32'd0,         2, 64'h00000005_FFFFFFFF, 1'b0, 1'b0);
      run_op("mul_minsq",  2'b00, 32'h80000000, 32'h80000000, 35, 64'h40000000_00000000, 1'b0, 1'b0);
      run_op("mul_pulse",  2'b00, 32'd100,      32'd200,      35, 64'h00000000_00004E20, 1'b0, 1'b1);
      run_op("mul_hold",   2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 35, 64'h00000000_0000001E, 1'b1, 1'b0);
      run_op("div_100_7",  2'b01, 32'd100,      32'd7,        35, 64'h00000002_0000000E, 1'b0, 1'b0);
`ifdef HILO_MULDIV_UNSIGNED_EN
      run_op("mulu",       2'b10, 32'hFFFFFFFF, 32'd2,        35, 64'h00000001_FFFFFFFE, 1'b0, 1'b0);
      run_op("divu",       2'b11, 32'hFFFFFFFF, 32'd2,        35, 64'h00000001_7FFFFFFF, 1'b0, 1'b0);
`else
      run_op("mulu",       2'b10, 32'hFFFFFFFF, 32'd2,        35, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0);
      run_op("divu",       2'b11, 32'hFFFFFFFF, 32'd2,        35, 64'hFFFFFFFF_00000000, 1'b0, 1'b0);
`endif
      run_op("divu_9_0",   2'b11, 32'd9,        32'd0,         2, 64'h00000009_FFFFFFFF, 1'b0, 1'b0);

      // Abort a multiply in flight.
      start = 1'b1;
      op    = 2'b00;
      a     = 32'd100;
      b     = 32'd3;
      for (int c = 1; c <= 10; c++) begin
         step();
         start = 1'b0;
      end
      chk("abort_busy_c10", {63'd0, busy}, 64'd1);
      clear = 1'b0;
      step();
      chk("abort_ctl", {61'd0, busy, done, hilo_en}, 64'b000);
      chk("abort_hilo", hilo_d, 64'd0);
      clear = 1'b1;
      step();
      run_op("mul_3_4",    2'b00, 32'd3,        32'd4,        35, 64'h00000000_0000000C, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
